// File: rtl/sat_pkg.sv
// ============================================================================
// Module      : sat_pkg
// Description : Shared types and default widths for the SAT core and its
//               unloader. Holds the unload item-kind enum, the unloader
//               state encoding and a small constant-function helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sat_pkg;

  // Default widths shared with sat_engine
  localparam int c_NUM_CLAUSES      = 8;
  localparam int c_NUM_VARS         = 8;
  localparam int c_NUM_LVLS         = 8;
  localparam int c_WIDTH_LVL        = 16;
  localparam int c_WIDTH_VAR_STATES = 19;
  localparam int c_WIDTH_LVL_STATES = 16;

  // Kind tag carried with every unloaded item
  typedef enum logic [1:0] {
    CLAUSE = 2'd0,
    VAR    = 2'd1,
    LVL    = 2'd2
  } unload_kind_e;

  // Unloader state encoding (kept as plain constants for legacy users)
  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_SNAP    = 3'd1;
  localparam logic [2:0] c_ST_CL_REQ  = 3'd2;
  localparam logic [2:0] c_ST_CL_CAP  = 3'd3;
  localparam logic [2:0] c_ST_CL_SEND = 3'd4;
  localparam logic [2:0] c_ST_VS_SEND = 3'd5;
  localparam logic [2:0] c_ST_LS_SEND = 3'd6;
  localparam logic [2:0] c_ST_DONE    = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = c_ST_IDLE,
    ST_SNAP    = c_ST_SNAP,
    ST_CL_REQ  = c_ST_CL_REQ,
    ST_CL_CAP  = c_ST_CL_CAP,
    ST_CL_SEND = c_ST_CL_SEND,
    ST_VS_SEND = c_ST_VS_SEND,
    ST_LS_SEND = c_ST_LS_SEND,
    ST_DONE    = c_ST_DONE
  } unload_state_e;

  // Largest of three sizes; used to size the shared index counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage : sat_pkg

`default_nettype wire

// File: rtl/core_unload_oreg.sv
// ============================================================================
// Module      : core_unload_oreg
// Description : Output item register of the core unloader. Loads the next
//               item every cycle except while an offered item is stalled
//               (valid high, ready low), so the presented item is held
//               stable until the sink accepts it.
// Ports       : clk, rst          - clock, async active-high reset
//               out_ready_i       - sink ready
//               nxt_*_i           - item to present on the following cycle
//               out_*_o           - registered item seen by the sink
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_unload_oreg
  import sat_pkg::*;
#(
  parameter int IDX_W  = 3,
  parameter int DATA_W = 19,
  parameter int BIN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_ready_i,
  input  logic              nxt_valid_i,
  input  unload_kind_e      nxt_kind_i,
  input  logic [IDX_W-1:0]  nxt_idx_i,
  input  logic [DATA_W-1:0] nxt_data_i,
  input  logic [BIN_W-1:0]  nxt_bin_i,
  output logic              out_valid_o,
  output logic [1:0]        out_kind_o,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [BIN_W-1:0]  out_bin_o
);

  logic w_hold;

  assign w_hold = out_valid_o & ~out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_kind_o  <= '0;
      out_idx_o   <= '0;
      out_data_o  <= '0;
      out_bin_o   <= '0;
    end else if (!w_hold) begin
      out_valid_o <= nxt_valid_i;
      out_kind_o  <= nxt_kind_i;
      out_idx_o   <= nxt_idx_i;
      out_data_o  <= nxt_data_i;
      out_bin_o   <= nxt_bin_i;
    end
  end

endmodule : core_unload_oreg

`default_nettype wire

// File: rtl/core_unloader.sv
// ============================================================================
// Module      : core_unloader
// Description : Streams the contents of a SAT core out over a valid/ready
//               port: every clause-array row (read through a one-hot strobe
//               with 1-cycle latency), then a snapshot of the var-state list,
//               then a snapshot of the level-state list, each ascending by
//               index and tagged with the bin number latched at start.
// Ports       : clk, rst            - clock, async active-high reset
//               start_unload_i      - start request (ignored while busy)
//               done_core_i         - core done pulse (auto-start option)
//               cur_bin_num_i       - bin number latched at start
//               rd_carray_o/clause_i- clause row read strobe / row data
//               vars_states_i       - var-state list (snapshotted)
//               lvl_states_i        - level-state list (snapshotted)
//               out_*               - item stream (valid/ready)
//               busy_o, done_unload_o - status
// Build macro : CORE_UNLOAD_AUTO_EN - when defined, done_core_i in IDLE also
//               starts an unload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_unloader
  import sat_pkg::*;
#(
  parameter int NUM_CLAUSES      = c_NUM_CLAUSES,
  parameter int NUM_VARS         = c_NUM_VARS,
  parameter int NUM_LVLS         = c_NUM_LVLS,
  parameter int WIDTH_LVL        = c_WIDTH_LVL,
  parameter int WIDTH_VAR_STATES = c_WIDTH_VAR_STATES,
  parameter int WIDTH_LVL_STATES = c_WIDTH_LVL_STATES
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_unload_i,
  input  logic                               done_core_i,
  input  logic [WIDTH_LVL-1:0]               cur_bin_num_i,
  output logic [NUM_CLAUSES-1:0]             rd_carray_o,
  input  logic [NUM_VARS*2-1:0]              clause_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [1:0]                         out_kind_o,
  output logic [$clog2(NUM_CLAUSES)-1:0]     out_idx_o,
  output logic [WIDTH_LVL-1:0]               out_bin_o,
  output logic [WIDTH_VAR_STATES-1:0]        out_data_o,
  output logic                               busy_o,
  output logic                               done_unload_o
);

  // One counter serves all three phases, so it is sized for the largest.
  // The reported index is NUM_CLAUSES wide; list sizes are expected not to
  // exceed NUM_CLAUSES.
  localparam int IW = $clog2(max3(NUM_CLAUSES, NUM_VARS, NUM_LVLS));
  localparam int OW = $clog2(NUM_CLAUSES);
  localparam int VW = $clog2(NUM_VARS);
  localparam int LW = $clog2(NUM_LVLS);

  localparam logic [IW-1:0] c_LAST_CL = IW'(NUM_CLAUSES - 1);
  localparam logic [IW-1:0] c_LAST_VS = IW'(NUM_VARS - 1);
  localparam logic [IW-1:0] c_LAST_LS = IW'(NUM_LVLS - 1);

  unload_state_e r_state, w_state_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;

  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] r_vs_snap;
  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] r_ls_snap;

  logic                        w_start;
  logic                        w_xfer;
  logic                        w_nxt_valid;
  unload_kind_e                w_nxt_kind;
  logic [WIDTH_VAR_STATES-1:0] w_nxt_data;
  logic [WIDTH_LVL-1:0]        w_bin_nxt;
  logic [VW-1:0]               w_vidx;
  logic [LW-1:0]               w_lidx;

`ifdef CORE_UNLOAD_AUTO_EN
  assign w_start = start_unload_i | done_core_i;
`else
  logic w_unused_done_core;
  assign w_start            = start_unload_i;
  assign w_unused_done_core = done_core_i;
`endif

  assign w_xfer        = out_valid_o & out_ready_i;
  assign busy_o        = (r_state != ST_IDLE);
  assign done_unload_o = (r_state == ST_DONE);
  assign rd_carray_o   = (r_state == ST_CL_REQ) ? (NUM_CLAUSES'(1) << r_idx) : '0;

  // --------------------------------------------------------------------------
  // State / index sequencing
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_SNAP;
          w_idx_nxt   = '0;
        end
      end
      ST_SNAP:   w_state_nxt = ST_CL_REQ;
      ST_CL_REQ: w_state_nxt = ST_CL_CAP;
      ST_CL_CAP: w_state_nxt = ST_CL_SEND;
      ST_CL_SEND: begin
        if (w_xfer) begin
          if (r_idx == c_LAST_CL) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_VS_SEND;
          end else begin
            w_idx_nxt   = r_idx + IW'(1);
            w_state_nxt = ST_CL_REQ;
          end
        end
      end
      ST_VS_SEND: begin
        if (w_xfer) begin
          if (r_idx == c_LAST_VS) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_LS_SEND;
          end else begin
            w_idx_nxt   = r_idx + IW'(1);
          end
        end
      end
      ST_LS_SEND: begin
        if (w_xfer) begin
          if (r_idx == c_LAST_LS) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt   = r_idx + IW'(1);
          end
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_vs_snap <= '0;
      r_ls_snap <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (r_state == ST_SNAP) begin
        r_vs_snap <= vars_states_i;
        r_ls_snap <= lvl_states_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next item, built from the next state so the output register presents it
  // in the cycle the FSM enters a send state. In CL_CAP the next state is
  // CL_SEND, so loading clause_i here is the 1-cycle-latency row capture.
  // --------------------------------------------------------------------------
  assign w_vidx = w_idx_nxt[VW-1:0];
  assign w_lidx = w_idx_nxt[LW-1:0];

  always_comb begin
    w_nxt_valid = 1'b0;
    w_nxt_kind  = CLAUSE;
    w_nxt_data  = '0;
    case (w_state_nxt)
      ST_CL_SEND: begin
        w_nxt_valid = 1'b1;
        w_nxt_kind  = CLAUSE;
        w_nxt_data  = WIDTH_VAR_STATES'(clause_i);
      end
      ST_VS_SEND: begin
        w_nxt_valid = 1'b1;
        w_nxt_kind  = VAR;
        w_nxt_data  = r_vs_snap[int'(w_vidx)*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
      end
      ST_LS_SEND: begin
        w_nxt_valid = 1'b1;
        w_nxt_kind  = LVL;
        w_nxt_data  = WIDTH_VAR_STATES'(r_ls_snap[int'(w_lidx)*WIDTH_LVL_STATES +: WIDTH_LVL_STATES]);
      end
      default: begin
        w_nxt_valid = 1'b0;
      end
    endcase
  end

  // Bin number is captured only when an unload is accepted in IDLE
  assign w_bin_nxt = ((r_state == ST_IDLE) && w_start) ? cur_bin_num_i : out_bin_o;

  core_unload_oreg #(
    .IDX_W  (OW),
    .DATA_W (WIDTH_VAR_STATES),
    .BIN_W  (WIDTH_LVL)
  ) u_oreg (
    .clk         (clk),
    .rst         (rst),
    .out_ready_i (out_ready_i),
    .nxt_valid_i (w_nxt_valid),
    .nxt_kind_i  (w_nxt_kind),
    .nxt_idx_i   (w_idx_nxt[OW-1:0]),
    .nxt_data_i  (w_nxt_data),
    .nxt_bin_i   (w_bin_nxt),
    .out_valid_o (out_valid_o),
    .out_kind_o  (out_kind_o),
    .out_idx_o   (out_idx_o),
    .out_data_o  (out_data_o),
    .out_bin_o   (out_bin_o)
  );

endmodule : core_unloader

`default_nettype wire
